// File: rtl/mem_wb_stage_pkg.sv
// Shared types, encodings and constants for the MEM/WB pipeline stage.
package mem_wb_stage_pkg;

  typedef logic [31:0] Reg_t;
  typedef logic [4:0]  RegAddr_t;

  typedef enum logic [2:0] {
    LOAD_LB   = 3'd0,
    LOAD_LBU  = 3'd1,
    LOAD_LH   = 3'd2,
    LOAD_LHU  = 3'd3,
    LOAD_LW   = 3'd4,
    LOAD_LWL  = 3'd5,
    LOAD_LWR  = 3'd6,
    LOAD_NONE = 3'd7
  } LoadOp_t;

  localparam Reg_t ZeroWord    = 32'h0000_0000;
  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  typedef struct packed {
    RegAddr_t   wd;
    logic       wreg;
    Reg_t       wdata;
    LoadOp_t    load_op;
    logic [1:0] addr_lo;
  } stage_t;

  localparam stage_t StageBubble = '{wd: 5'd0, wreg: 1'b0, wdata: ZeroWord,
                                     load_op: LOAD_NONE, addr_lo: 2'd0};

  function automatic Reg_t ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic Reg_t ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side inputs, RAM/pipeline control and regfile write port of the MEM/WB stage.
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  RegAddr_t   mem_wd;
  logic       mem_wreg;
  Reg_t       mem_wdata;
  LoadOp_t    mem_load_op;
  logic [1:0] mem_addr_lo;
  Reg_t       ram_rdata;
  logic       stall_mem;
  logic       stall_wb;
  logic       flush;
  logic       wb_we;
  RegAddr_t   wb_waddr;
  Reg_t       wb_wdata;
  logic       wb_busy_load;

  modport master (
    output mem_wd, mem_wreg, mem_wdata, mem_load_op, mem_addr_lo,
    output ram_rdata, stall_mem, stall_wb, flush,
    input  wb_we, wb_waddr, wb_wdata, wb_busy_load
  );

  modport slave (
    input  mem_wd, mem_wreg, mem_wdata, mem_load_op, mem_addr_lo,
    input  ram_rdata, stall_mem, stall_wb, flush,
    output wb_we, wb_waddr, wb_wdata, wb_busy_load
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load alignment: byte/half extraction, extension and LWL/LWR merge with rt.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  LoadOp_t    op,
  input  logic [1:0] addr_lo,
  input  Reg_t       ram,
  input  Reg_t       rt,
  output Reg_t       data,
  output logic       ok
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // byte k of the word sits at ram[31-8k:24-8k]
  always_comb begin
    byte_s = ram[31:24];
    half_s = addr_lo[1] ? ram[15:0] : ram[31:16];
    case (addr_lo)
      2'd0:    byte_s = ram[31:24];
      2'd1:    byte_s = ram[23:16];
      2'd2:    byte_s = ram[15:8];
      2'd3:    byte_s = ram[7:0];
      default: byte_s = ram[31:24];
    endcase
  end

  // result select; misaligned halfword loads suppress the write
  always_comb begin
    data = rt;
    ok   = 1'b1;
    case (op)
      LOAD_LB:  data = ext8(byte_s, 1'b1);
      LOAD_LBU: data = ext8(byte_s, 1'b0);
      LOAD_LH: begin
        data = ext16(half_s, 1'b1);
        ok   = ~addr_lo[0];
      end
      LOAD_LHU: begin
        data = ext16(half_s, 1'b0);
        ok   = ~addr_lo[0];
      end
      LOAD_LW:  data = ram;
      LOAD_LWL: begin
        case (addr_lo)
          2'd0:    data = ram;
          2'd1:    data = {ram[23:0], rt[7:0]};
          2'd2:    data = {ram[15:0], rt[15:0]};
          2'd3:    data = {ram[7:0],  rt[23:0]};
          default: data = ram;
        endcase
      end
      LOAD_LWR: begin
        case (addr_lo)
          2'd0:    data = {rt[31:8],  ram[31:24]};
          2'd1:    data = {rt[31:16], ram[31:16]};
          2'd2:    data = {rt[31:24], ram[31:8]};
          2'd3:    data = ram;
          default: data = ram;
        endcase
      end
      LOAD_NONE: data = rt;
      default:   data = rt;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data hold across WB stalls and regfile write generation.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);

  stage_t stage_r;
  Reg_t   hold_reg;
  logic   hold_valid;
  Reg_t   align_ram_s;
  Reg_t   align_data_s;
  logic   align_ok_s;

  // stage register and RAM-data hold; hold_valid only survives while the stage holds
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stage_r    <= StageBubble;
      hold_reg   <= ZeroWord;
      hold_valid <= 1'b0;
    end else if (bus.flush) begin
      stage_r    <= StageBubble;
      hold_valid <= 1'b0;
    end else if (bus.stall_mem && !bus.stall_wb) begin
      stage_r    <= StageBubble;
      hold_valid <= 1'b0;
    end else if (!bus.stall_mem) begin
      stage_r    <= '{wd: bus.mem_wd, wreg: bus.mem_wreg, wdata: bus.mem_wdata,
                      load_op: bus.mem_load_op, addr_lo: bus.mem_addr_lo};
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_reg   <= bus.ram_rdata;
      hold_valid <= 1'b1;
    end else begin
      hold_reg   <= hold_reg;
      hold_valid <= hold_valid;
    end
  end

  assign align_ram_s = hold_valid ? hold_reg : bus.ram_rdata;

  load_align u_align (
    .op      (stage_r.load_op),
    .addr_lo (stage_r.addr_lo),
    .ram     (align_ram_s),
    .rt      (stage_r.wdata),
    .data    (align_data_s),
    .ok      (align_ok_s)
  );

  assign bus.wb_we        = (stage_r.wreg == WriteEnable) && (stage_r.wd != 5'd0) && align_ok_s;
  assign bus.wb_waddr     = stage_r.wd;
  assign bus.wb_wdata     = align_data_s;
  assign bus.wb_busy_load = (stage_r.load_op != LOAD_NONE) && stage_r.wreg;

endmodule
